// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle shared by the command master and its CSR slave.
// Every channel moves one beat on a rising edge where valid && ready; once valid is high
// the source holds it and its payload unchanged until that edge, and ready may change freely.
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Turns word-indexed register commands into single AXI4-Lite reads/writes, one outstanding,
// and returns status, read data and a timeout flag on a valid/ready response port.
module axi4_lite_cmd_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          IDX_W          = 8,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [IDX_W-1:0] cmd_idx_i,
  input  logic [31:0]      cmd_wdata_i,
  input  logic [3:0]       cmd_wstrb_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic [1:0]       rsp_resp_o,
  output logic             rsp_timeout_o,
  output logic [2:0]       dbg_state_o,
  axi4_lite_if.master      csr_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      r_state;
  state_t      w_next;
  logic        r_ready_en;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_drain;
  logic [31:0] r_tmo_cnt;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_resp;
  logic        r_rsp_timeout;

  logic        w_awvalid;
  logic        w_wvalid;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_accept;
  logic        w_b_done;
  logic        w_r_done;
  logic        w_expire;
  logic        w_tmo_hit;
  logic [31:0] w_cmd_addr;

  assign w_cmd_addr = BASE_ADDR + (32'(cmd_idx_i) << 2);
  assign w_awvalid  = (r_state == WR_REQ) && !r_aw_done;
  assign w_wvalid   = (r_state == WR_REQ) && !r_w_done;
  assign w_aw_hs    = w_awvalid && csr_o.awready;
  assign w_w_hs     = w_wvalid && csr_o.wready;
  assign w_tmo_hit  = TMO_EN && (r_tmo_cnt == TMO_LAST);

  // A B/R beat is checked before expiry so a response on the last cycle is not a timeout.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_b_done = 1'b0;
    w_r_done = 1'b0;
    w_expire = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i && r_ready_en) begin
          w_accept = 1'b1;
          w_next   = cmd_we_i ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
      end
      WR_RESP: begin
        if (csr_o.bvalid) begin
          w_b_done = 1'b1;
          w_next   = RSP;
        end else if (w_tmo_hit) begin
          w_expire = 1'b1;
          w_next   = RSP;
        end
      end
      RD_REQ: begin
        if (csr_o.arready) w_next = RD_RESP;
      end
      RD_RESP: begin
        if (csr_o.rvalid) begin
          w_r_done = 1'b1;
          w_next   = RSP;
        end else if (w_tmo_hit) begin
          w_expire = 1'b1;
          w_next   = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) w_next = r_drain ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (r_we ? csr_o.bvalid : csr_o.rvalid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // r_ready_en keeps cmd_ready_o low while reset is held and for the first cycle after.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ready_en    <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= 32'h0;
      r_wdata       <= 32'h0;
      r_wstrb       <= 4'h0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_drain       <= 1'b0;
      r_tmo_cnt     <= 32'h0;
      r_rsp_rdata   <= 32'h0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_we          <= cmd_we_i;
        r_addr        <= w_cmd_addr;
        r_wdata       <= cmd_wdata_i;
        r_wstrb       <= cmd_wstrb_i;
        r_aw_done     <= 1'b0;
        r_w_done      <= 1'b0;
        r_drain       <= 1'b0;
        r_rsp_timeout <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if ((r_state == WR_RESP) || (r_state == RD_RESP)) r_tmo_cnt <= r_tmo_cnt + 32'd1;
      else                                               r_tmo_cnt <= 32'h0;
      if (w_b_done) begin
        r_rsp_resp  <= csr_o.bresp;
        r_rsp_rdata <= 32'h0;
      end
      if (w_r_done) begin
        r_rsp_resp  <= csr_o.rresp;
        r_rsp_rdata <= csr_o.rdata;
      end
      if (w_expire) begin
        r_rsp_timeout <= 1'b1;
        r_rsp_resp    <= 2'b00;
        r_rsp_rdata   <= 32'h0;
        r_drain       <= 1'b1;
      end
    end
  end

  assign cmd_ready_o   = (r_state == IDLE) && r_ready_en;
  assign rsp_valid_o   = (r_state == RSP);
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_resp_o    = r_rsp_resp;
  assign rsp_timeout_o = r_rsp_timeout;
  assign dbg_state_o   = r_state;

  assign csr_o.awaddr  = r_addr;
  assign csr_o.awprot  = 3'b000;
  assign csr_o.awvalid = w_awvalid;
  assign csr_o.wdata   = r_wdata;
  assign csr_o.wstrb   = r_wstrb;
  assign csr_o.wvalid  = w_wvalid;
  assign csr_o.bready  = (r_state == WR_RESP) || ((r_state == DRAIN) && r_we);
  assign csr_o.araddr  = r_addr;
  assign csr_o.arprot  = 3'b000;
  assign csr_o.arvalid = (r_state == RD_REQ);
  assign csr_o.rready  = (r_state == RD_RESP) || ((r_state == DRAIN) && !r_we);

endmodule
